// File: rtl/mcpu_ram_arb.sv
`default_nettype none
// ============================================================================
// Module      : mcpu_ram_arb
// Description : Shared-RAM arbiter between a main CPU and a video/DMA reader.
//               DMA has priority, but a pending CPU cycle is granted after at
//               most DMA_MAX back-to-back DMA accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mcpu_ram_arb #(
    parameter int AW      = 12,
    parameter int DMA_MAX = 4
) (
    input  logic          clk_sys,
    input  logic          reset,

    input  logic          cpu_cs,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_ab,
    input  logic [7:0]    cpu_dout,
    output logic [7:0]    cpu_din,
    output logic          cpu_wait_n,

    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    output logic          dma_ack,
    output logic [7:0]    dma_data,

    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_CPU_ACC  = 3'd1;
    localparam logic [2:0] c_CPU_DONE = 3'd2;
    localparam logic [2:0] c_DMA_ACC  = 3'd3;
    localparam logic [2:0] c_DMA_DONE = 3'd4;

    // Out-of-range values are clamped so the 4-bit fairness counter can reach the limit.
    localparam int         c_DMA_MAX_CL = (DMA_MAX < 1) ? 1 : ((DMA_MAX > 15) ? 15 : DMA_MAX);
    localparam logic [3:0] c_DMA_MAX    = 4'(c_DMA_MAX_CL);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic       r_served;
    logic [3:0] r_dcnt;
    logic [7:0] r_cpu_din;
    logic [7:0] r_dma_data;
    logic       r_dma_ack;
    logic [7:0] r_wdata;

    logic       w_cpu_req;
    logic       w_cpu_pend;
    logic       w_cpu_wins;

    assign w_cpu_req  = cpu_cs & (cpu_rd | cpu_wr);
    assign w_cpu_pend = w_cpu_req & ~r_served;
    assign w_cpu_wins = w_cpu_pend & (~dma_req | (r_dcnt == c_DMA_MAX));

    assign cpu_wait_n = reset | ~w_cpu_pend;
    assign cpu_din    = r_cpu_din;
    assign dma_data   = r_dma_data;
    assign dma_ack    = r_dma_ack;

    always_comb begin
        w_state_nxt = r_state;
        ram_addr    = dma_addr;
        ram_wdata   = r_wdata;
        ram_we      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_cpu_wins) begin
                    w_state_nxt = c_CPU_ACC;
                end else if (dma_req) begin
                    w_state_nxt = c_DMA_ACC;
                end
            end
            c_CPU_ACC: begin
                w_state_nxt = c_CPU_DONE;
                ram_addr    = cpu_ab;
                // A reset landing on the access cycle must not let the write through.
                if (!reset) begin
                    ram_wdata = cpu_dout;
                    ram_we    = cpu_wr;
                end
            end
            c_CPU_DONE: w_state_nxt = c_IDLE;
            c_DMA_ACC:  w_state_nxt = c_DMA_DONE;
            c_DMA_DONE: w_state_nxt = c_IDLE;
            default:    w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_served   <= 1'b0;
            r_dcnt     <= 4'd0;
            r_cpu_din  <= 8'h00;
            r_dma_data <= 8'h00;
            r_dma_ack  <= 1'b0;
            r_wdata    <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_dma_ack <= (r_state == c_DMA_DONE);

            if (r_state == c_CPU_ACC) begin
                r_wdata <= cpu_dout;
            end

            if (r_state == c_CPU_DONE && cpu_rd) begin
                r_cpu_din <= ram_rdata;
            end

            if (r_state == c_DMA_DONE) begin
                r_dma_data <= ram_rdata;
            end

            // Served sticks for the rest of the bus cycle and drops once the request goes away.
            r_served <= w_cpu_req & (r_served | (r_state == c_CPU_DONE));

            if (r_state == c_CPU_DONE) begin
                r_dcnt <= 4'd0;
            end else if (r_state == c_DMA_DONE && w_cpu_pend && r_dcnt != c_DMA_MAX) begin
                r_dcnt <= r_dcnt + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mcpu_ram_arb.md
MCPU_RAM_ARB -- requirements
Module: mcpu_ram_arb

Interface
REQ-001 SHALL have parameter AW, default 12, shared RAM address width.
REQ-002 SHALL have parameter DMA_MAX, default 4, the maximum number of consecutive DMA grants while a CPU request is pending; legal range 1..15.
REQ-003 SHALL have port clk_sys  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port cpu_cs  in  1  main-CPU memory cycle decoded to shared RAM.
REQ-006 SHALL have port cpu_rd  in  1  CPU read strobe, active high.
REQ-007 SHALL have port cpu_wr  in  1  CPU write strobe, active high.
REQ-008 SHALL have port cpu_ab  in  AW  CPU address.
REQ-009 SHALL have port cpu_dout  in  8  CPU write data.
REQ-010 SHALL have port cpu_din  out  8  registered CPU read data.
REQ-011 SHALL have port cpu_wait_n  out  1  CPU wait, low stalls the CPU.
REQ-012 SHALL have port dma_req  in  1  video/DMA read request, level.
REQ-013 SHALL have port dma_addr  in  AW  DMA address.
REQ-014 SHALL have port dma_ack  out  1  one-cycle pulse; dma_data is valid in that cycle.
REQ-015 SHALL have port dma_data  out  8  registered DMA read data.
REQ-016 SHALL have port ram_addr  out  AW  RAM address.
REQ-017 SHALL have port ram_we  out  1  RAM write enable.
REQ-018 SHALL have port ram_wdata  out  8  RAM write data.
REQ-019 SHALL have port ram_rdata  in  8  RAM read data, valid 1 cycle after the address is presented.

Function
REQ-020 SHALL define cpu_req = cpu_cs & (cpu_rd | cpu_wr).
REQ-021 SHALL implement FSM states IDLE, CPU_ACC, CPU_DONE, DMA_ACC and DMA_DONE.
REQ-022 IDLE SHALL go to CPU_ACC if cpu_req & ~served & (~dma_req | dcnt==DMA_MAX); else to DMA_ACC if dma_req; else stay in IDLE.
REQ-023 CPU_ACC SHALL drive ram_addr=cpu_ab, ram_wdata=cpu_dout and ram_we=cpu_wr for exactly one cycle, then go to CPU_DONE.
REQ-024 CPU_DONE SHALL, on a read, load cpu_din<=ram_rdata, set served=1, clear dcnt, and return to IDLE.
REQ-025 DMA_ACC SHALL drive ram_addr=dma_addr with ram_we=0, then go to DMA_DONE.
REQ-026 DMA_DONE SHALL load dma_data<=ram_rdata, pulse dma_ack for one cycle, saturating-increment dcnt if cpu_req & ~served, and return to IDLE.
REQ-027 served SHALL clear on the cycle after cpu_req falls; one CPU bus cycle SHALL produce at most one RAM access.
REQ-028 cpu_wait_n SHALL equal ~(cpu_req & ~served), driven combinationally, and SHALL be 1 while reset is high.
REQ-029 ram_we SHALL be high only in CPU_ACC with cpu_wr=1; it SHALL never be high in DMA states.
REQ-030 Outside CPU_ACC, ram_addr SHALL hold dma_addr and ram_wdata SHALL hold its last value.
REQ-031 CPU read latency SHALL be 3 cycles from cpu_req rise to cpu_wait_n high in the uncontended case: IDLE, CPU_ACC, CPU_DONE.
REQ-032 DMA read latency SHALL be 2 cycles from IDLE grant to dma_ack: DMA_ACC, then DMA_DONE.
REQ-033 If cpu_req and dma_req rise simultaneously with dcnt<DMA_MAX, DMA SHALL win.
REQ-034 A CPU request SHALL be granted after no more than DMA_MAX DMA accesses.
REQ-035 If dma_req drops during DMA_ACC, the access SHALL complete and dma_ack SHALL still pulse.
REQ-036 If cpu_req drops before grant, no RAM access SHALL occur for it.

Reset
REQ-037 Reset SHALL set state=IDLE, served=0, dcnt=0, cpu_din=0, dma_data=0, dma_ack=0, ram_we=0, ram_wdata=0.
REQ-038 Reset asserted mid-access SHALL abort the access, with no ram_we and no dma_ack in or after the reset cycle.

Verification
REQ-039 CPU write, addr 0x123, data 0xA5, no DMA -> one ram_we pulse with addr 0x123 and data 0xA5; cpu_wait_n high 3 cycles after request.
REQ-040 CPU read of addr 0x010, RAM holding 0x5C -> cpu_din=0x5C when cpu_wait_n rises; exactly one RAM access for a request held 10 cycles.
REQ-041 dma_req held continuously plus CPU read, DMA_MAX=4 -> exactly 4 dma_ack pulses, then a CPU grant, then DMA resumes.
REQ-042 Simultaneous first cpu_req and dma_req -> DMA_ACC first; CPU served immediately after dma_ack.
REQ-043 reset asserted in CPU_ACC of a write -> ram_we low in the reset cycle, state IDLE, cpu_wait_n=1 during reset.
REQ-044 dma_req pulsed for 1 cycle -> exactly one dma_ack, 2 cycles after grant.
